h_or16: RTL and testbench
=========================

// Module: h_or16
//
// PURPOSE
//  - 16-bit bitwise OR for the Hack-computer base gate library (Or16 level).
//  - out is purely combinational, with zero latency.
//  - Also provides a registered copy with a valid flag for clocked datapath users (ALU staging, test harnesses).
//
// PARAMETERS
//  - WIDTH  16  operand/result width; all tests use 16
//
// PORTS
//  - clk         in   1      rising-edge clock
//  - rst_n       in   1      asynchronous, active-low reset
//  - a           in   WIDTH  operand A
//  - b           in   WIDTH  operand B
//  - in_valid    in   1      capture a|b into out_q on this edge
//  - out         out  WIDTH  combinational a|b
//  - out_q       out  WIDTH  registered result
//  - out_valid   out  1      out_q was updated on the last edge
//  - zero_q      out  1      [H_OR16_STATUS_EN] out_q == 0
//  - ones_q      out  1      [H_OR16_STATUS_EN] out_q == all ones
//
// BEHAVIOUR
//  - Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n).
//  - out[i] = a[i] | b[i] for every bit:
//    - combinational, no clock involvement;
//    - valid in and out of reset;
//    - X on an input propagates only where the other bit is 0.
//  - Reset (rst_n low, asynchronous assert, synchronous-to-clk release):
//    - out_q=0, out_valid=0, zero_q=1, ones_q=0.
//  - Each rising clk with rst_n high:
//    - out_valid <= in_valid;
//    - if in_valid: out_q <= a|b, else out_q holds.
//  - Latency and throughput:
//    - out: 0 cycles;
//    - out_q / out_valid: exactly 1 cycle;
//    - a new operand may be accepted every cycle, no backpressure.
//  - in_valid low: out_q holds its last value; out_valid drops to 0 the next cycle.
//  - Reset asserted mid-stream: registers clear immediately; the in-flight result is discarded.
//  - Width rule: no carry or extension; bit i of the result depends only on bit i of a and b.
//
// CONFIGURATION
//  - Macro H_OR16_STATUS_EN.
//  - Defined:
//    - zero_q and ones_q ports exist;
//    - both are registered alongside out_q, computed from a|b on the capture edge;
//    - both hold when in_valid is low.
//  - Undefined: the ports and their logic are absent; all other behaviour is identical.
//
// STRUCTURE
//  - Shared package hack_base_pkg holds:
//    - localparam HACK_WORD_W = 16;
//    - typedef logic [15:0] hack_word_t.
//  - One sub-module, h_or_bit:
//    - 1-bit OR, out = a | b;
//    - generate-instantiated WIDTH times to form out.
//  - Registers are in h_or16 itself.
//
// TESTING
//  1. a=0000, b=0000 -> out=0000; after an in_valid edge: out_q=0000, zero_q=1.
//  2. a=00FF, b=FF00 -> out=FFFF; with in_valid, the next edge gives out_q=FFFF, out_valid=1, ones_q=1.
//  3. a=F0F0, b=0F0F -> out=FFFF; with a=FF00, b=0F0F -> out=FF0F, ones_q=0, zero_q=0.
//  4. Back-to-back in_valid on 00FF|FF00, then FF00|0F0F -> out_q=FFFF, then FF0F on consecutive edges.
//  5. in_valid=0 with a=1234, b=0000 -> out=1234 immediately; out_q keeps its previous value; out_valid=0.
//  6. Pulse rst_n low between edges after capturing FFFF -> out_q=0, out_valid=0 with no clock edge.

Source files
------------

// File: rtl/hack_base_pkg.sv
// Shared Hack base-gate definitions: machine word width and word type.
package hack_base_pkg;

    localparam int HACK_WORD_W = 16;

    typedef logic [15:0] hack_word_t;

endpackage : hack_base_pkg

// File: rtl/h_or_bit.sv
// Single-bit OR gate, the leaf cell replicated by h_or16.
module h_or_bit (
    input  logic a,
    input  logic b,
    output logic out
);

    assign out = a | b;

endmodule : h_or_bit

// File: rtl/h_or16.sv
// Hack Or16: combinational bitwise OR plus a registered copy with valid flag.
// Optional status flags (zero_q, ones_q) are built when H_OR16_STATUS_EN is defined.
module h_or16
    import hack_base_pkg::*;
#(
    parameter int WIDTH = HACK_WORD_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic [WIDTH-1:0] out,
`ifdef H_OR16_STATUS_EN
    output logic             zero_q,
    output logic             ones_q,
`endif
    output logic [WIDTH-1:0] out_q,
    output logic             out_valid
);

    // Each result bit comes from its own gate, so no bit can influence another.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        h_or_bit u_bit (
            .a   (a[i]),
            .b   (b[i]),
            .out (out[i])
        );
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q     <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_q <= out;
            end
        end
    end

`ifdef H_OR16_STATUS_EN
    // Flags track out_q: computed from the word being captured, held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q <= 1'b1;
            ones_q <= 1'b0;
        end else if (in_valid) begin
            zero_q <= (out == '0);
            ones_q <= (out == '1);
        end
    end
`endif

endmodule : h_or16

// File: tb/tb_h_or16.sv
// Self-checking bench for h_or16: vector table plus scoreboard, reset corner cases.
// Status-flag checks are compiled in when H_OR16_STATUS_EN is defined.
module tb_h_or16;
    import hack_base_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    hack_word_t a, b, out, out_q;
    logic       in_valid, out_valid;
`ifdef H_OR16_STATUS_EN
    logic       zero_q, ones_q;
`endif

    int         errors = 0;
    int         checks = 0;
    hack_word_t sb[$];
    hack_word_t held;

    typedef struct {
        hack_word_t va;
        hack_word_t vb;
        logic       vv;
        hack_word_t vexp;
    } vec_t;

    vec_t vecs[10];

    h_or16 #(.WIDTH(HACK_WORD_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .out       (out),
`ifdef H_OR16_STATUS_EN
        .zero_q    (zero_q),
        .ones_q    (ones_q),
`endif
        .out_q     (out_q),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_regs(input string name);
        check({name, "_out_q"}, 32'(out_q), 32'(held));
`ifdef H_OR16_STATUS_EN
        check({name, "_zero_q"}, 32'(zero_q), 32'(held == 16'h0000));
        check({name, "_ones_q"}, 32'(ones_q), 32'(held == 16'hFFFF));
`endif
    endtask

    // Drive one operand pair away from the edge, check out at once, then the
    // registered view one edge later.
    task automatic apply(input hack_word_t ta, input hack_word_t tb_v, input logic tv,
                         input hack_word_t texp, input string name);
        @(negedge clk);
        a        = ta;
        b        = tb_v;
        in_valid = tv;
        if (tv) sb.push_back(texp);
        #1;
        check({name, "_out"}, 32'(out), 32'(texp));
        @(posedge clk);
        #1;
        check({name, "_out_valid"}, 32'(out_valid), 32'(tv));
        if (tv) begin
            if (sb.size() == 0) begin
                check({name, "_sb_empty"}, 32'(1), 32'(0));
            end else begin
                held = sb.pop_front();
            end
        end
        check_regs(name);
    endtask

    initial begin
        vecs[0] = '{16'h0000, 16'h0000, 1'b1, 16'h0000};
        vecs[1] = '{16'h00FF, 16'hFF00, 1'b1, 16'hFFFF};
        vecs[2] = '{16'hF0F0, 16'h0F0F, 1'b1, 16'hFFFF};
        vecs[3] = '{16'hFF00, 16'h0F0F, 1'b1, 16'hFF0F};
        vecs[4] = '{16'h1234, 16'h0000, 1'b0, 16'h1234};
        vecs[5] = '{16'h00FF, 16'hFF00, 1'b1, 16'hFFFF};
        vecs[6] = '{16'hFF00, 16'h0F0F, 1'b1, 16'hFF0F};
        vecs[7] = '{16'h8000, 16'h0001, 1'b1, 16'h8001};
        vecs[8] = '{16'hA5A5, 16'h5A5A, 1'b0, 16'hFFFF};
        vecs[9] = '{16'h0000, 16'h0000, 1'b1, 16'h0000};

        // Reset state, with out live during reset.
        held     = 16'h0000;
        rst_n    = 1'b0;
        a        = 16'h1234;
        b        = 16'h0001;
        in_valid = 1'b1;
        #1;
        check("rst_out", 32'(out), 32'h1235);
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check_regs("rst");
        @(posedge clk);
        #1;
        check("rst_hold_out_valid", 32'(out_valid), 32'(0));
        check_regs("rst_hold");
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;

        for (int i = 0; i < 10; i++) begin
            apply(vecs[i].va, vecs[i].vb, vecs[i].vv, vecs[i].vexp, $sformatf("vec%0d", i));
        end

        // Capture FFFF, then pulse reset between edges.
        apply(16'h00FF, 16'hFF00, 1'b1, 16'hFFFF, "pre_rst");
        @(negedge clk);
        a        = 16'h0F0F;
        b        = 16'h0000;
        in_valid = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        sb.delete();
        held = 16'h0000;
        check("mid_rst_out_valid", 32'(out_valid), 32'(0));
        check_regs("mid_rst");
        rst_n = 1'b1;
        in_valid = 1'b0;
        apply(16'h1234, 16'h0000, 1'b0, 16'h1234, "post_rst_idle");
        apply(16'h0001, 16'h0002, 1'b1, 16'h0003, "post_rst_cap");

        // Random back-to-back traffic against the scoreboard.
        for (int i = 0; i < 20; i++) begin
            hack_word_t ra, rb;
            logic       rv;
            ra = hack_word_t'($urandom);
            rb = hack_word_t'($urandom);
            rv = 1'($urandom_range(0, 3) != 0);
            apply(ra, rb, rv, ra | rb, $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_h_or16
